// File: rtl/sign_narrow_packer_pkg.sv
// Shared types and constants for the 32->16 sign-narrowing packer.
package sign_narrow_packer_pkg;

    // Pack FSM states: nothing held, low halfword held, output word presented.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StHalf  = 2'd1,
        StFull  = 2'd2
    } pack_state_e;

    // Saturation limits of a signed 16-bit halfword.
    localparam logic [15:0] HALF_MAX = 16'h7FFF;
    localparam logic [15:0] HALF_MIN = 16'h8000;

endpackage

// File: rtl/sign_narrow.sv
// Combinational 32->16 signed narrowing with range check and optional saturation.
module sign_narrow
    import sign_narrow_packer_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic [31:0] data_i,
    output logic [15:0] narrow_o,
    output logic        ovf_o
);

    logic in_range;

    // In range exactly when bits [31:15] are a valid sign extension of bit 15.
    assign in_range = (&data_i[31:15]) | ~(|data_i[31:15]);
    assign ovf_o    = ~in_range;

    // Out-of-range words clamp toward the sign of the source, or wrap to the low bits.
    always_comb begin
        narrow_o = data_i[15:0];
        if (!in_range && SATURATE) begin
            narrow_o = data_i[31] ? HALF_MIN : HALF_MAX;
        end
    end

endmodule

// File: rtl/sign_narrow_packer.sv
// Narrows signed 32-bit words to 16 bits and packs pairs into 32-bit output words.
module sign_narrow_packer
    import sign_narrow_packer_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    input  logic        last_i,
    output logic        ready_o,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        half_o,
    output logic        ovf_o,
    input  logic        ovf_clr_i
);

    pack_state_e state_q, state_d;
    logic [15:0] low_q, low_d;
    logic [31:0] data_q, data_d;
    logic        half_q, half_d;
    logic        ovf_q, ovf_d;

    logic [15:0] narrow;
    logic        narrow_ovf;
    logic        accept;

    sign_narrow #(
        .SATURATE (SATURATE)
    ) u_sign_narrow (
        .data_i   (data_i),
        .narrow_o (narrow),
        .ovf_o    (narrow_ovf)
    );

    // A presented word blocks input only while downstream is stalling it.
    assign ready_o = (state_q != StFull) || ready_i;
    assign accept  = valid_i && ready_o;

    // Next-state: capture halfwords, complete packs, drain the output word.
    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        data_d  = data_q;
        half_d  = half_q;
        ovf_d   = ovf_q;

        // Overflow set wins over a same-cycle clear.
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (accept && narrow_ovf) begin
            ovf_d = 1'b1;
        end

        unique case (state_q)
            StEmpty, StFull: begin
                // StFull only reaches here with ready_i=1 if it accepts or drains.
                if (state_q == StFull && ready_i && !accept) begin
                    state_d = StEmpty;
                end
                if (accept) begin
                    if (last_i) begin
                        data_d  = {16'h0000, narrow};
                        half_d  = 1'b1;
                        state_d = StFull;
                    end else begin
                        low_d   = narrow;
                        state_d = StHalf;
                    end
                end
            end
            StHalf: begin
                if (accept) begin
                    data_d  = {narrow, low_q};
                    half_d  = 1'b0;
                    state_d = StFull;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    // State and output registers; reset discards any held halfword.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            low_q   <= 16'h0000;
            data_q  <= 32'h0000_0000;
            half_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            data_q  <= data_d;
            half_q  <= half_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = (state_q == StFull);
    assign data_o  = data_q;
    assign half_o  = half_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_sign_narrow_packer.sv
// Self-checking bench: saturating and wrapping instances driven in lockstep.
module tb_sign_narrow_packer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        last_i;
    logic        ready_i;
    logic        ovf_clr_i;

    logic        rdy_s, vld_s, half_s, ovf_s;
    logic [31:0] data_s;
    logic        rdy_w, vld_w, half_w, ovf_w;
    logic [31:0] data_w;

    always #5 clk_i = ~clk_i;

    sign_narrow_packer #(
        .SATURATE (1'b1)
    ) u_sat (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .last_i    (last_i),
        .ready_o   (rdy_s),
        .data_o    (data_s),
        .valid_o   (vld_s),
        .ready_i   (ready_i),
        .half_o    (half_s),
        .ovf_o     (ovf_s),
        .ovf_clr_i (ovf_clr_i)
    );

    sign_narrow_packer #(
        .SATURATE (1'b0)
    ) u_wrap (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .last_i    (last_i),
        .ready_o   (rdy_w),
        .data_o    (data_w),
        .valid_o   (vld_w),
        .ready_i   (ready_i),
        .half_o    (half_w),
        .ovf_o     (ovf_w),
        .ovf_clr_i (ovf_clr_i)
    );

    typedef struct {
        logic [31:0] ds;
        logic [31:0] dw;
        logic        half;
    } exp_t;

    typedef struct {
        logic [31:0] din;
        logic [15:0] exp_sat;
        logic [15:0] exp_wrap;
        logic        exp_ovf;
    } vec_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state
    bit          m_full;
    bit          m_have_low;
    logic [15:0] m_low_s, m_low_w;
    bit          m_ovf;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Independent range model using signed integer limits.
    function automatic void ref_narrow(input logic [31:0] d, input bit sat,
                                       output logic [15:0] n, output bit oor);
        int sd;
        sd  = $signed(d);
        oor = (sd > 32767) || (sd < -32768);
        if (oor && sat) n = (sd < 0) ? 16'h8000 : 16'h7FFF;
        else            n = d[15:0];
    endfunction

    // One clock: drive inputs, check handshake/output, advance model, check ovf.
    task automatic cycle(input logic v, input logic [31:0] d, input logic l,
                         input logic r, input logic c);
        logic        exp_rdy;
        logic        acc;
        logic [15:0] ns, nw;
        bit          oor;
        exp_t        e;
        valid_i = v; data_i = d; last_i = l; ready_i = r; ovf_clr_i = c;
        #1;
        exp_rdy = !m_full || r;
        chk1("ready_o sat", rdy_s, exp_rdy);
        chk1("ready_o wrap", rdy_w, exp_rdy);
        chk1("valid_o sat", vld_s, m_full);
        chk1("valid_o wrap", vld_w, m_full);
        if (m_full) begin
            if (sb.size() == 0) begin
                chk1("scoreboard nonempty", 1'b0, 1'b1);
            end else begin
                chk32("data_o sat", data_s, sb[0].ds);
                chk32("data_o wrap", data_w, sb[0].dw);
                chk1("half_o sat", half_s, sb[0].half);
                chk1("half_o wrap", half_w, sb[0].half);
                if (r) void'(sb.pop_front());
            end
            if (r) m_full = 0;
        end
        acc = v && exp_rdy;
        if (c) m_ovf = 0;
        if (acc) begin
            ref_narrow(d, 1'b1, ns, oor);
            ref_narrow(d, 1'b0, nw, oor);
            if (oor) m_ovf = 1;
            if (m_have_low) begin
                e.ds = {ns, m_low_s}; e.dw = {nw, m_low_w}; e.half = 1'b0;
                sb.push_back(e);
                m_full = 1; m_have_low = 0;
            end else if (l) begin
                e.ds = {16'h0000, ns}; e.dw = {16'h0000, nw}; e.half = 1'b1;
                sb.push_back(e);
                m_full = 1;
            end else begin
                m_low_s = ns; m_low_w = nw; m_have_low = 1;
            end
        end
        @(posedge clk_i);
        #1;
        chk1("ovf_o sat", ovf_s, m_ovf);
        chk1("ovf_o wrap", ovf_w, m_ovf);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; valid_i = 1'b1; data_i = 32'h7FFF_FFFF; last_i = 1'b0;
        ready_i = 1'b0; ovf_clr_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0; valid_i = 1'b0;
        m_full = 0; m_have_low = 0; m_ovf = 0; m_low_s = '0; m_low_w = '0;
        sb.delete();
        #1;
        chk1("reset valid_o", vld_s, 1'b0);
        chk1("reset half_o", half_s, 1'b0);
        chk32("reset data_o", data_s, 32'h0);
        chk1("reset ovf_o", ovf_s, 1'b0);
        chk1("reset ready_o", rdy_s, 1'b1);
        chk1("reset ready_o wrap", rdy_w, 1'b1);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'h0000_1234, 16'h1234, 16'h1234, 1'b0};
        vecs[1] = '{32'hFFFF_8000, 16'h8000, 16'h8000, 1'b0};
        vecs[2] = '{32'h0000_7FFF, 16'h7FFF, 16'h7FFF, 1'b0};
        vecs[3] = '{32'h0000_8000, 16'h7FFF, 16'h8000, 1'b1};
        vecs[4] = '{32'hFFFF_7FFF, 16'h8000, 16'h7FFF, 1'b1};
        vecs[5] = '{32'hFFFF_FFFE, 16'hFFFE, 16'hFFFE, 1'b0};
        vecs[6] = '{32'h8000_0000, 16'h8000, 16'h0000, 1'b1};
        vecs[7] = '{32'h7FFF_FFFF, 16'h7FFF, 16'hFFFF, 1'b1};
        vecs[8] = '{32'h0001_2345, 16'h7FFF, 16'h2345, 1'b1};
        vecs[9] = '{32'hFFFE_0000, 16'h8000, 16'h0000, 1'b1};

        do_reset();

        // Table: single-word flushes; same-cycle clear shows set priority.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, vecs[i].din, 1'b1, 1'b1, 1'b1);
            chk32("tbl data sat", data_s, {16'h0000, vecs[i].exp_sat});
            chk32("tbl data wrap", data_w, {16'h0000, vecs[i].exp_wrap});
            chk1("tbl half", half_s, 1'b1);
            chk1("tbl ovf", ovf_s, vecs[i].exp_ovf);
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        end

        // Basic pair
        do_reset();
        cycle(1'b1, 32'h0000_1234, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'hFFFF_8000, 1'b0, 1'b1, 1'b0);
        chk32("pair data", data_s, 32'h8000_1234);
        chk1("pair half", half_s, 1'b0);
        chk1("pair ovf", ovf_s, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Saturate vs wrap pair; ovf set from the first accept
        do_reset();
        cycle(1'b1, 32'h0001_2345, 1'b0, 1'b1, 1'b0);
        chk1("sat ovf first", ovf_s, 1'b1);
        cycle(1'b1, 32'hFFFE_0000, 1'b0, 1'b1, 1'b0);
        chk32("sat pair", data_s, 32'h8000_7FFF);
        chk32("wrap pair", data_w, 32'h0000_2345);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Range boundaries
        do_reset();
        cycle(1'b1, 32'h0000_7FFF, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'hFFFF_8000, 1'b0, 1'b1, 1'b0);
        chk32("bound in", data_s, 32'h8000_7FFF);
        chk1("bound in ovf", ovf_s, 1'b0);
        cycle(1'b1, 32'h0000_8000, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'hFFFF_7FFF, 1'b0, 1'b1, 1'b0);
        chk32("bound out", data_s, 32'h8000_7FFF);
        chk1("bound out ovf", ovf_s, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Backpressure: hold for 3 cycles, then drain and accept together
        do_reset();
        cycle(1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0002, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0);
            chk32("stall data", data_s, 32'h0002_0001);
            chk1("stall ready", rdy_s, 1'b0);
        end
        cycle(1'b1, 32'h0000_0003, 1'b0, 1'b1, 1'b0);
        chk1("drain+accept valid", vld_s, 1'b0);
        chk1("drain+accept ready", rdy_s, 1'b1);
        // Held half persists with no input
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0004, 1'b1, 1'b1, 1'b0);
        chk32("after stall pack", data_s, 32'h0004_0003);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Reset in HALF discards the stale halfword
        do_reset();
        cycle(1'b1, 32'h0000_AAAA, 1'b0, 1'b1, 1'b0);
        do_reset();
        cycle(1'b1, 32'h0000_0011, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0022, 1'b0, 1'b1, 1'b0);
        chk32("post-reset pair", data_s, 32'h0022_0011);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        // Clear alone, then clear with overflowing accept
        cycle(1'b1, 32'h1000_0000, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk1("ovf cleared", ovf_s, 1'b0);
        cycle(1'b1, 32'hF000_0000, 1'b1, 1'b1, 1'b1);
        chk1("ovf set beats clr", ovf_s, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Streaming throughput with ready held high
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'h0000_0100 + i, 1'b0, 1'b1, 1'b0);
            chk1("stream ready", rdy_s, 1'b1);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Randomised traffic checked by the scoreboard
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rd;
            rd = $urandom();
            if ($urandom_range(0, 1) == 0) rd = {{16{rd[15]}}, rd[15:0]};
            cycle(1'($urandom_range(0, 3) != 0), rd, 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sign_narrow_packer.md
SIGN_NARROW_PACKER -- requirements
Module: sign_narrow_packer

Interface
REQ-001 SHALL have parameter SATURATE, default 1; 1 = saturate out-of-range words, 0 = wrap by keeping bits [15:0].
REQ-002 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port data_i  input  32  signed word to narrow to 16 bits.
REQ-005 SHALL have port valid_i  input  1  data_i/last_i valid.
REQ-006 SHALL have port last_i  input  1  final word of burst; forces flush of a partial pack.
REQ-007 SHALL have port ready_o  output  1  block accepts input this cycle.
REQ-008 SHALL have port data_o  output  32  packed word {second half, first half}; first-accepted halfword in [15:0].
REQ-009 SHALL have port valid_o  output  1  data_o valid.
REQ-010 SHALL have port ready_i  input  1  downstream accepts data_o.
REQ-011 SHALL have port half_o  output  1  1 = only data_o[15:0] meaningful (odd flush), [31:16] = 16'h0000.
REQ-012 SHALL have port ovf_o  output  1  sticky overflow flag.
REQ-013 SHALL have port ovf_clr_i  input  1  clears ovf_o.

Function
REQ-014 SHALL accept a word when valid_i && ready_o; ready_o = (state != FULL) || ready_i.
REQ-015 SHALL deem a word in range iff data_i[31:15] are all equal (the exact inverse of 16->32 sign extension).
REQ-016 SHALL narrow an in-range word to data_i[15:0]; out-of-range: SATURATE=1 gives 16'h7FFF if data_i[31]=0, else 16'h8000; SATURATE=0 gives data_i[15:0].
REQ-017 SHALL set ovf_o on the clock edge that accepts an out-of-range word; set has priority over a simultaneous ovf_clr_i.
REQ-018 SHALL implement states EMPTY, HALF (low halfword held) and FULL (valid_o=1).
REQ-019 EMPTY, accept with last_i=0: store narrowed value as low half, go to HALF.
REQ-020 EMPTY, accept with last_i=1: data_o={16'h0000, narrowed}, half_o=1, go to FULL.
REQ-021 HALF, accept (last_i ignored): data_o={narrowed, low}, half_o=0, go to FULL.
REQ-022 FULL, ready_i=1, no accept: go to EMPTY, valid_o=0 next cycle.
REQ-023 FULL, ready_i=1 with accept: drain and capture in one cycle, proceed as in REQ-019/REQ-020.
REQ-024 FULL, ready_i=0: data_o, half_o and valid_o SHALL hold stable; ready_o=0.
REQ-025 Latency: valid_o rises the cycle after the accept that completes a pack; sustained throughput 2 words in per 2 cycles with ready_i held high.
REQ-026 HALF with no valid_i SHALL hold indefinitely; no timeout flush.

Reset
REQ-027 rst_i=1 at a clock edge SHALL force state EMPTY, valid_o=0, half_o=0, data_o=32'h0, ovf_o=0, discarding any held halfword; rst_i has priority over all inputs.
REQ-028 ready_o SHALL be 1 in the cycle after reset.

Structure
REQ-029 Shared package SHALL hold state encodings (EMPTY/HALF/FULL) and constants HALF_MAX=16'h7FFF, HALF_MIN=16'h8000.
REQ-030 Range check and saturation SHALL be one combinational sub-module, sign_narrow (32 in, 16 out, ovf out, SATURATE parameter); the rest is the FSM and registers.

Verification
REQ-031 Pair 0x00001234, 0xFFFF8000, ready_i=1 -> data_o=0x80001234, half_o=0, ovf_o=0.
REQ-032 SATURATE=1: 0x00012345, 0xFFFE0000 -> data_o=0x80007FFF, ovf_o=1 from the edge accepting the first word; SATURATE=0 same stimulus -> 0x00002345.
REQ-033 Boundaries: 0x00007FFF, 0xFFFF8000 -> 0x80007FFF, ovf_o=0; then 0x00008000, 0xFFFF7FFF (SATURATE=1) -> 0x80007FFF, ovf_o=1.
REQ-034 Single word 0xFFFFFFFE with last_i=1 -> data_o=0x0000FFFE, half_o=1.
REQ-035 Backpressure: FULL with ready_i=0 for 3 cycles -> data_o stable, ready_o=0; then ready_i=1 with valid_i=1 -> drain and accept in the same cycle, state HALF.
REQ-036 rst_i asserted in HALF -> next pair packs without the stale half; ovf_clr_i together with an overflowing accept -> ovf_o stays 1.
